// File: rtl/delta_scan_engine.sv
// Delta-array scan engine: signed counter memory with MIN/MAX marked-index search and MADD prefix-sum scan.
// Define DSCAN_SAT_EN to clamp the MADD total at its range limits and report it on ovf.
module delta_scan_engine #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 6,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cmd,
  input  logic [IDX_W-1:0]       index,
  input  logic [DATA_W-1:0]      data,
  input  logic                   load,
  input  logic                   run,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ovf,
  output logic [OUT_W-1:0]       out,
  output logic [ACC_W-OUT_W-1:0] out_top
);

  localparam int DEPTH = 2**IDX_W;
  localparam logic [1:0] CMD_MIN   = 2'd0;
  localparam logic [1:0] CMD_MAX   = 2'd1;
  localparam logic [1:0] CMD_MADD  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;
  localparam logic [IDX_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic signed [CNT_W-1:0] mem [DEPTH];
  state_t                  state;
  logic [1:0]              mode;
  logic [IDX_W-1:0]        ptr;
  logic signed [ACC_W-1:0] d, cnt;
  logic [ACC_W-1:0]        tot, result;

  logic                    scanning, load_ok, run_ok, req_err;
  logic signed [CNT_W-1:0] data_ext, mem_cur;
  logic signed [ACC_W-1:0] mem_ext, d_nxt, cnt_nxt;
  logic [ACC_W-1:0]        tot_nxt;
  logic                    tot_flag;

  // Returns {clamped, value}; the total is an unsigned quantity fed by a signed increment.
`ifdef DSCAN_SAT_EN
  function automatic logic [ACC_W:0] tot_add(input logic [ACC_W-1:0] t,
                                             input logic signed [ACC_W-1:0] c);
    logic [ACC_W+1:0] s;
    s = {2'b00, t} + {{2{c[ACC_W-1]}}, c};
    if (s[ACC_W+1])    tot_add = {1'b1, {ACC_W{1'b0}}};
    else if (s[ACC_W]) tot_add = {1'b1, {ACC_W{1'b1}}};
    else               tot_add = {1'b0, s[ACC_W-1:0]};
  endfunction
`else
  function automatic logic [ACC_W:0] tot_add(input logic [ACC_W-1:0] t,
                                             input logic signed [ACC_W-1:0] c);
    tot_add = {1'b0, t + $unsigned(c)};
  endfunction
`endif

  assign scanning = (state == SCAN);
  assign load_ok  = load & ~run & ~scanning;
  assign run_ok   = run & ~load & ~scanning & (cmd != CMD_CLEAR);
  assign req_err  = (load & run) | (scanning & (load | run)) |
                    (run & ~load & ~scanning & (cmd == CMD_CLEAR));

  assign data_ext = $signed({{(CNT_W-DATA_W){1'b0}}, data});
  assign mem_cur  = mem[ptr];
  assign mem_ext  = $signed({{(ACC_W-CNT_W){mem_cur[CNT_W-1]}}, mem_cur});
  assign d_nxt    = d + mem_ext;
  assign cnt_nxt  = cnt + d_nxt;
  assign {tot_flag, tot_nxt} = tot_add(tot, cnt_nxt);

  assign out     = result[OUT_W-1:0];
  assign out_top = result[ACC_W-1:OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_ok) begin
      case (cmd)
        CMD_MIN, CMD_MAX: mem[index] <= {{(CNT_W-1){1'b0}}, 1'b1};
        CMD_MADD: begin
          mem[index] <= mem[index] + data_ext;
          if (index != '0) mem[index - 1'b1] <= mem[index - 1'b1] - data_ext;
        end
        default: for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode   <= CMD_MIN;
      ptr    <= '0;
      d      <= '0;
      cnt    <= '0;
      tot    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (req_err) err <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (load_ok) begin
            if (cmd == CMD_CLEAR) err <= 1'b0;
            state <= IDLE;
            done  <= 1'b0;
          end else if (run_ok) begin
            mode  <= cmd;
            ptr   <= (cmd == CMD_MIN) ? '0 : PTR_LAST;
            d     <= '0;
            cnt   <= '0;
            tot   <= '0;
            ovf   <= 1'b0;
            state <= SCAN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        SCAN: begin
          case (mode)
            CMD_MADD: begin
              d   <= d_nxt;
              cnt <= cnt_nxt;
              tot <= tot_nxt;
              if (tot_flag) ovf <= 1'b1;
              if (ptr == '0) begin
                result <= tot_nxt;
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                ptr <= ptr - 1'b1;
              end
            end
            CMD_MIN: begin
              if (mem_cur != '0 || ptr == PTR_LAST) begin
                result <= (mem_cur != '0) ? {{(ACC_W-IDX_W){1'b0}}, ptr} : {ACC_W{1'b1}};
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end
            default: begin
              if (mem_cur != '0 || ptr == '0) begin
                result <= (mem_cur != '0) ? {{(ACC_W-IDX_W){1'b0}}, ptr} : {ACC_W{1'b1}};
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                ptr <= ptr - 1'b1;
              end
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
